// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes, immediate formats and decode helpers shared by the decode stage.
package rv_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;

  function automatic imm_type_t imm_type(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    case (imm_type(i[6:0]))
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return imm_type(op) != IMM_NONE || op == OP_REG || op == OP_FENCE || op == OP_SYSTEM;
  endfunction
endpackage

// File: rtl/id_regfile_stage_if.sv
// id_regfile_stage_if: fetch, hazard, write-back and decode signals of the decode stage.
// Optional id_illegal present when ILLEGAL_OPCODE_EN is defined.
interface id_regfile_stage_if #(parameter int XLEN = 32, parameter int PC_W = 8) ();
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            stall;
  logic            flush;
  logic            id_ready;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            id_valid;
  logic [PC_W-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
`ifdef ILLEGAL_OPCODE_EN
  logic            id_illegal;
`endif

  modport master (
    output if_valid, if_pc, if_instr, stall, flush, wb_en, wb_rd, wb_data,
    input  id_ready, id_valid, id_pc, id_instr, id_opcode, id_rd, id_rs1, id_rs2,
           id_rs1_data, id_rs2_data, id_imm
`ifdef ILLEGAL_OPCODE_EN
    , input id_illegal
`endif
  );

  modport slave (
    input  if_valid, if_pc, if_instr, stall, flush, wb_en, wb_rd, wb_data,
    output id_ready, id_valid, id_pc, id_instr, id_opcode, id_rd, id_rs1, id_rs2,
           id_rs1_data, id_rs2_data, id_imm
`ifdef ILLEGAL_OPCODE_EN
    , output id_illegal
`endif
  );
endinterface

// File: rtl/id_regfile_stage_regfile_2r1w.sv
// regfile_2r1w: 32-entry register file, two asynchronous reads, one synchronous write, x0 reads 0.
module regfile_2r1w #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0)
      regs[wa] <= wd;

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

// File: rtl/id_regfile_stage.sv
// id_regfile_stage: IF/ID pipeline register with stall/flush, field decode, immediate and operand fetch.
// Define ILLEGAL_OPCODE_EN to add the id_illegal output.
module id_regfile_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 8
) (
  input logic clk,
  input logic rst,
  id_regfile_stage_if.slave bus
);
  logic            valid_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] op1_q, op2_q, rd1, rd2;
  logic [31:0]     nxt_instr;
  logic [4:0]      nrs1, nrs2, cur_rs1, cur_rs2;
  logic            byp1, byp2, ref1, ref2;

  assign nxt_instr = bus.if_valid ? bus.if_instr : NOP_INSTR;
  assign nrs1      = nxt_instr[19:15];
  assign nrs2      = nxt_instr[24:20];
  assign cur_rs1   = instr_q[19:15];
  assign cur_rs2   = instr_q[24:20];

  // a write landing in the same edge as the capture must be seen by the captured operand
  assign byp1 = bus.wb_en && bus.wb_rd == nrs1 && nrs1 != 5'd0;
  assign byp2 = bus.wb_en && bus.wb_rd == nrs2 && nrs2 != 5'd0;
  assign ref1 = bus.wb_en && bus.wb_rd == cur_rs1 && cur_rs1 != 5'd0;
  assign ref2 = bus.wb_en && bus.wb_rd == cur_rs2 && cur_rs2 != 5'd0;

  regfile_2r1w #(.XLEN(XLEN)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (bus.wb_en),
    .wa  (bus.wb_rd),
    .wd  (bus.wb_data),
    .ra1 (nrs1),
    .ra2 (nrs2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      op1_q   <= '0;
      op2_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      op1_q   <= '0;
      op2_q   <= '0;
    end else if (bus.stall) begin
      op1_q <= ref1 ? bus.wb_data : op1_q;
      op2_q <= ref2 ? bus.wb_data : op2_q;
    end else begin
      valid_q <= bus.if_valid;
      pc_q    <= bus.if_pc;
      instr_q <= nxt_instr;
      op1_q   <= byp1 ? bus.wb_data : rd1;
      op2_q   <= byp2 ? bus.wb_data : rd2;
    end

  assign bus.id_ready    = !bus.stall;
  assign bus.id_valid    = valid_q;
  assign bus.id_pc       = pc_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_opcode   = instr_q[6:0];
  assign bus.id_rd       = instr_q[11:7];
  assign bus.id_rs1      = cur_rs1;
  assign bus.id_rs2      = cur_rs2;
  assign bus.id_rs1_data = op1_q;
  assign bus.id_rs2_data = op2_q;
  assign bus.id_imm      = XLEN'(signed'(imm_gen(instr_q)));
`ifdef ILLEGAL_OPCODE_EN
  assign bus.id_illegal  = valid_q && !is_legal(instr_q[6:0]);
`endif
endmodule

// File: tb/tb_id_regfile_stage.sv
// tb_id_regfile_stage: directed vectors with a queue scoreboard checked by an independent monitor.
module tb_id_regfile_stage;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_regfile_stage_if #(.XLEN(32), .PC_W(8)) bus ();
  id_regfile_stage #(.XLEN(32), .PC_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        v;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, op1, op2;
    int          due;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic v, input logic [7:0] pc, input logic [31:0] instr,
                              input logic [4:0] rd, rs1, rs2, input logic [31:0] imm, op1, op2);
    exp_t e;
    e.v = v; e.pc = pc; e.instr = instr; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.op1 = op1; e.op2 = op2; e.due = 0;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    chk("id_ready", {31'b0, bus.id_ready}, {31'b0, !bus.stall});
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("id_valid", {31'b0, bus.id_valid}, {31'b0, e.v});
      chk("id_pc", {24'b0, bus.id_pc}, {24'b0, e.pc});
      chk("id_instr", bus.id_instr, e.instr);
      chk("id_opcode", {25'b0, bus.id_opcode}, {25'b0, e.instr[6:0]});
      chk("id_rd", {27'b0, bus.id_rd}, {27'b0, e.rd});
      chk("id_rs1", {27'b0, bus.id_rs1}, {27'b0, e.rs1});
      chk("id_rs2", {27'b0, bus.id_rs2}, {27'b0, e.rs2});
      chk("id_imm", bus.id_imm, e.imm);
      chk("id_rs1_data", bus.id_rs1_data, e.op1);
      chk("id_rs2_data", bus.id_rs2_data, e.op2);
    end
  end

  task automatic go(input logic iv, input logic [7:0] pc, input logic [31:0] ins,
                    input logic st, input logic fl, input logic we, input logic [4:0] wr,
                    input logic [31:0] wd, input exp_t e);
    bus.if_valid = iv;
    bus.if_pc    = pc;
    bus.if_instr = ins;
    bus.stall    = st;
    bus.flush    = fl;
    bus.wb_en    = we;
    bus.wb_rd    = wr;
    bus.wb_data  = wd;
    e.due = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.if_valid = 1'b1;
    bus.if_pc    = 8'haa;
    bus.if_instr = 32'hfff00093;
    bus.stall    = 1'b1;
    bus.flush    = 1'b0;
    bus.wb_en    = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'd123;
    @(posedge clk);
    #1;
    // second reset cycle still tries to write x1 and stall/flush: reset must win
    go(1'b1, 8'haa, 32'hfff00093, 1'b1, 1'b1, 1'b1, 5'd1, 32'd123,
       mk(1'b0, 8'h00, NOP_INSTR, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      logic [31:0] ins;
      ins = {7'b0, 5'(i), 5'(i), 3'b0, 5'b0, 7'b0110011};
      go(1'b1, 8'(i), ins, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
         mk(1'b1, 8'(i), ins, 5'd0, 5'(i), 5'(i), 32'd0, 32'd0, 32'd0));
    end
    go(1'b1, 8'h04, 32'h00f00193, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h04, 32'h00f00193, 5'd3, 5'd0, 5'd15, 32'd15, 32'd0, 32'd0));
    go(1'b1, 8'h08, 32'h06502223, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h08, 32'h06502223, 5'd4, 5'd0, 5'd5, 32'd100, 32'd0, 32'd0));
    go(1'b1, 8'h0c, 32'h00518863, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h0c, 32'h00518863, 5'd16, 5'd3, 5'd5, 32'd16, 32'd0, 32'd0));
    go(1'b1, 8'h10, 32'h05d22183, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h10, 32'h05d22183, 5'd3, 5'd4, 5'd29, 32'd93, 32'd0, 32'd0));
    go(1'b1, 8'h14, 32'hfff00093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h14, 32'hfff00093, 5'd1, 5'd0, 5'd31, 32'hffffffff, 32'd0, 32'd0));
    go(1'b1, 8'h18, 32'h123450b7, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h18, 32'h123450b7, 5'd1, 5'd8, 5'd3, 32'h12345000, 32'd0, 32'd0));
    go(1'b1, 8'h1c, 32'h0080006f, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h1c, 32'h0080006f, 5'd0, 5'd0, 5'd8, 32'd8, 32'd0, 32'd0));
    // invalid fetch loads NOP while x3 is written; then an x0 write
    go(1'b0, 8'h20, 32'hdeadbeef, 1'b0, 1'b0, 1'b1, 5'd3, 32'd7,
       mk(1'b0, 8'h20, NOP_INSTR, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    go(1'b0, 8'h24, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'd0, 32'hffffffff,
       mk(1'b0, 8'h24, NOP_INSTR, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    go(1'b1, 8'h28, 32'h004182b3, 1'b0, 1'b0, 1'b1, 5'd4, 32'd22,
       mk(1'b1, 8'h28, 32'h004182b3, 5'd5, 5'd3, 5'd4, 32'd0, 32'd7, 32'd22));
    go(1'b1, 8'h2c, 32'h00400133, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h2c, 32'h00400133, 5'd2, 5'd0, 5'd4, 32'd0, 32'd0, 32'd22));
    go(1'b1, 8'h30, 32'h00118333, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h30, 32'h00118333, 5'd6, 5'd3, 5'd1, 32'd0, 32'd7, 32'd0));
    // three stalled cycles: hold, then refresh rs1 (x3) and rs2 (x1) from write-back
    go(1'b1, 8'h34, 32'hfff00093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h30, 32'h00118333, 5'd6, 5'd3, 5'd1, 32'd0, 32'd7, 32'd0));
    go(1'b1, 8'h34, 32'hfff00093, 1'b1, 1'b0, 1'b1, 5'd3, 32'h55,
       mk(1'b1, 8'h30, 32'h00118333, 5'd6, 5'd3, 5'd1, 32'd0, 32'h55, 32'd0));
    go(1'b1, 8'h34, 32'hfff00093, 1'b1, 1'b0, 1'b1, 5'd1, 32'h99,
       mk(1'b1, 8'h30, 32'h00118333, 5'd6, 5'd3, 5'd1, 32'd0, 32'h55, 32'h99));
    go(1'b1, 8'h34, 32'hfff00093, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0,
       mk(1'b0, 8'h30, NOP_INSTR, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    go(1'b1, 8'h38, 32'h00118333, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b1, 8'h38, 32'h00118333, 5'd6, 5'd3, 5'd1, 32'd0, 32'h55, 32'h99));
    go(1'b1, 8'h3c, 32'hfff00093, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,
       mk(1'b0, 8'h38, NOP_INSTR, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    go(1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
       mk(1'b0, 8'h00, NOP_INSTR, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
